// File: rtl/subword_store_unit.sv
// subword_store_unit
//
// Store path between the CPU datapath and a word-wide data memory.
// Word stores are written straight through. Byte and halfword stores do a
// read-modify-write: the addressed word is read, the selected lane(s) are
// replaced with the low bits of the register value, and the merged word is
// written back. Misaligned or reserved-size requests are rejected without
// any memory access.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_addr/data/size    byte address, register value, size (00 b, 01 h, 10 w)
//   done                  one-cycle pulse when the write is issued
//   misaligned            one-cycle pulse when a request is rejected
//   mem_addr              word-aligned address of the latched request
//   mem_re / mem_rdata    read strobe, data returned one cycle later
//   mem_we / mem_wdata    write strobe and write data

module subword_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_MERGE  = 3'd2,
        S_WRITE  = 3'd3,
        S_REJECT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         data_q, data_d;   // only the low half ever reaches a sub-word merge
    logic [1:0]          size_q, size_d;
    logic [31:0]         wdata_q, wdata_d;

    logic [3:0]          lane_en;
    logic [31:0]         merged;
    logic                req_reject;

    // Sizes: 00 byte (any lane), 01 half (even address), 10 word (aligned).
    assign req_reject = (req_size == 2'b11)
                     || ((req_size == 2'b01) && req_addr[0])
                     || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    // Per-lane merge. A byte store selects exactly one lane; a half store
    // selects the lower or upper lane pair, with the odd lane of the pair
    // taking data bits [15:8].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_en[gi] = (size_q == 2'b00) ? (addr_q[1:0] == LANE)
                                                   : (addr_q[1] == LANE[1]);
            assign merged[8*gi +: 8] =
                !lane_en[gi]                       ? mem_rdata[8*gi +: 8] :
                ((size_q == 2'b01) && LANE[0])     ? data_q[15:8]
                                                   : data_q[7:0];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    data_d = req_data[15:0];
                    size_d = req_size;
                    if (req_reject) begin
                        state_d = S_REJECT;
                    end else if (req_size == 2'b10) begin
                        wdata_d = req_data;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:   state_d = S_MERGE;
            S_MERGE: begin
                wdata_d = merged;
                state_d = S_WRITE;
            end
            S_WRITE:  state_d = S_IDLE;
            S_REJECT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
        end
    end

    // Strobes are decoded from state and masked by reset so that a reset
    // arriving in the WRITE cycle suppresses the write itself, and a request
    // presented alongside reset is never advertised as accepted.
    assign req_ready  = (state_q == S_IDLE)   && !reset;
    assign mem_re     = (state_q == S_READ)   && !reset;
    assign mem_we     = (state_q == S_WRITE)  && !reset;
    assign done       = (state_q == S_WRITE)  && !reset;
    assign misaligned = (state_q == S_REJECT) && !reset;
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_subword_store_unit.sv
// Directed bench for subword_store_unit. Inputs change and outputs are
// sampled on the falling edge; a small memory model returns mem_word one
// cycle after mem_re and a poison pattern otherwise.

module tb_subword_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        done;
    logic        misaligned;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata = '0;
    logic        mem_we;
    logic [31:0] mem_wdata;

    logic [31:0] mem_word = 32'h1122_3344;
    int          total = 0;
    int          bad = 0;
    int          we_cnt = 0;

    subword_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_size   (req_size),
        .done       (done),
        .misaligned (misaligned),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata)
    );

    always #5 clk = ~clk;

    // Memory model: data valid exactly one cycle after mem_re.
    always @(posedge clk) begin
        mem_rdata <= (mem_re === 1'b1) ? mem_word : 32'hA5A5_A5A5;
        if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
    end

    // Present a request for one cycle (A), then scramble the request fields
    // and return at the falling edge of cycle A+1.
    task automatic start_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_before_accept got=%b want=1", req_ready); end
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
        @(negedge clk);
        req_valid = 1'b0; req_addr = ~a; req_data = ~d; req_size = ~s;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (misaligned !== 1'b0)  begin bad++; $display("FAIL rst_misaligned got=%b want=0", misaligned); end
        total++; if (mem_re !== 1'b0)      begin bad++; $display("FAIL rst_mem_re got=%b want=0", mem_re); end
        total++; if (mem_we !== 1'b0)      begin bad++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
        total++; if (mem_addr !== 32'h0)   begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0)  begin bad++; $display("FAIL rst_mem_wdata got=%h want=0", mem_wdata); end
        reset = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1)   begin bad++; $display("FAIL rst_ready got=%b want=1", req_ready); end
        $display("txn reset released");
    endtask

    task automatic test_word();
        start_req(32'h0000_0010, 32'hDEAD_BEEF, 2'b10);
        total++; if (mem_we !== 1'b1)            begin bad++; $display("FAIL word_we got=%b want=1", mem_we); end
        total++; if (done !== 1'b1)              begin bad++; $display("FAIL word_done got=%b want=1", done); end
        total++; if (mem_re !== 1'b0)            begin bad++; $display("FAIL word_re got=%b want=0", mem_re); end
        total++; if (mem_addr !== 32'h10)        begin bad++; $display("FAIL word_addr got=%h want=00000010", mem_addr); end
        total++; if (mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL word_wdata got=%h want=deadbeef", mem_wdata); end
        @(negedge clk);
        total++; if (req_ready !== 1'b1)         begin bad++; $display("FAIL word_ready got=%b want=1", req_ready); end
        total++; if (mem_we !== 1'b0 || done !== 1'b0 || mem_re !== 1'b0)
            begin bad++; $display("FAIL word_idle_strobes got=we%b done%b re%b want=000", mem_we, done, mem_re); end
        $display("txn word addr=00000010 wdata=%h", mem_wdata);
    endtask

    task automatic do_subword(input string nm, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] s, input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
        start_req(a, d, s);
        // A+1: read
        total++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL %s_read got=re%b we%b want=re1 we0", nm, mem_re, mem_we); end
        total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL %s_addr got=%h want=%h", nm, mem_addr, exp_addr); end
        @(negedge clk);
        // A+2: merge
        total++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL %s_merge got=re%b we%b done%b want=000", nm, mem_re, mem_we, done); end
        @(negedge clk);
        // A+3: write
        total++; if (mem_we !== 1'b1 || done !== 1'b1 || mem_re !== 1'b0)
            begin bad++; $display("FAIL %s_write got=we%b done%b re%b want=110", nm, mem_we, done, mem_re); end
        total++; if (mem_wdata !== exp_wdata) begin bad++; $display("FAIL %s_wdata got=%h want=%h", nm, mem_wdata, exp_wdata); end
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL %s_ready got=rdy%b we%b want=rdy1 we0", nm, req_ready, mem_we); end
        $display("txn %s addr=%h wdata=%h", nm, a, exp_wdata);
    endtask

    task automatic test_byte_lanes();
        mem_word = 32'h1122_3344;
        do_subword("byte0", 32'h20, 32'hFFFF_FFAB, 2'b00, 32'h20, 32'h1122_33AB);
        do_subword("byte1", 32'h21, 32'hFFFF_FFAB, 2'b00, 32'h20, 32'h1122_AB44);
        do_subword("byte2", 32'h22, 32'hFFFF_FFAB, 2'b00, 32'h20, 32'h11AB_3344);
        do_subword("byte3", 32'h23, 32'hFFFF_FFAB, 2'b00, 32'h20, 32'hAB22_3344);
    endtask

    task automatic test_half();
        mem_word = 32'h1122_3344;
        do_subword("half_hi", 32'h32, 32'h0000_BEEF, 2'b01, 32'h30, 32'hBEEF_3344);
        do_subword("half_lo", 32'h30, 32'h0000_BEEF, 2'b01, 32'h30, 32'h1122_BEEF);
    endtask

    task automatic do_reject(input string nm, input logic [31:0] a, input logic [1:0] s);
        start_req(a, 32'h1234_5678, s);
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL %s_misaligned got=%b want=1", nm, misaligned); end
        total++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL %s_strobes got=re%b we%b done%b want=000", nm, mem_re, mem_we, done); end
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || misaligned !== 1'b0)
            begin bad++; $display("FAIL %s_ready got=rdy%b mis%b want=rdy1 mis0", nm, req_ready, misaligned); end
        $display("txn %s addr=%h size=%b rejected", nm, a, s);
    endtask

    task automatic test_rejects();
        do_reject("rej_half", 32'h41, 2'b01);
        do_reject("rej_word", 32'h42, 2'b10);
        do_reject("rej_rsvd", 32'h40, 2'b11);
    endtask

    task automatic test_reset_midop();
        int we0;
        we0 = we_cnt;
        start_req(32'h21, 32'h0000_0077, 2'b00);   // now in A+1
        @(negedge clk);                              // A+2
        reset = 1'b1;
        @(negedge clk);
        total++; if (mem_we !== 1'b0 || done !== 1'b0 || mem_re !== 1'b0 || misaligned !== 1'b0)
            begin bad++; $display("FAIL midrst_strobes got=we%b done%b re%b mis%b want=0000", mem_we, done, mem_re, misaligned); end
        total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
            begin bad++; $display("FAIL midrst_regs got=addr%h wdata%h want=0/0", mem_addr, mem_wdata); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (we_cnt !== we0) begin bad++; $display("FAIL midrst_no_write got=%0d want=%0d", we_cnt, we0); end
        $display("txn reset mid-op, writes=%0d", we_cnt - we0);
        start_req(32'h60, 32'hCAFE_F00D, 2'b10);
        total++; if (mem_we !== 1'b1 || mem_wdata !== 32'hCAFE_F00D || mem_addr !== 32'h60)
            begin bad++; $display("FAIL midrst_next got=we%b addr%h wdata%h want=we1 addr00000060 wdatacafef00d", mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        $display("txn word after reset addr=00000060 wdata=cafef00d");
    endtask

    task automatic test_write_suppress();
        start_req(32'h70, 32'h0BAD_F00D, 2'b10);    // A+1 is WRITE
        reset = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL suppress got=we%b done%b want=00", mem_we, done); end
        @(negedge clk);
        reset = 1'b0;
        $display("txn word write suppressed by reset");
    endtask

    task automatic test_back_to_back();
        mem_word = 32'h1122_3344;
        @(negedge clk);                              // cycle A
        req_valid = 1'b1; req_addr = 32'h50; req_data = 32'h1234_5678; req_size = 2'b10;
        @(negedge clk);                              // A+1
        total++; if (mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678)
            begin bad++; $display("FAIL b2b_word got=we%b wdata%h want=we1 wdata12345678", mem_we, mem_wdata); end
        req_addr = 32'h53; req_data = 32'h0000_00CD; req_size = 2'b00;
        @(negedge clk);                              // A+2: second accepted
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", req_ready); end
        @(negedge clk);                              // A+3
        req_valid = 1'b0;
        total++; if (mem_re !== 1'b1 || mem_addr !== 32'h50)
            begin bad++; $display("FAIL b2b_read got=re%b addr%h want=re1 addr00000050", mem_re, mem_addr); end
        @(negedge clk);                              // A+4
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL b2b_early_we got=%b want=0", mem_we); end
        @(negedge clk);                              // A+5
        total++; if (mem_we !== 1'b1 || done !== 1'b1 || mem_wdata !== 32'hCD22_3344)
            begin bad++; $display("FAIL b2b_byte got=we%b done%b wdata%h want=we1 done1 wdatacd223344", mem_we, done, mem_wdata); end
        @(negedge clk);                              // A+6
        total++; if (req_ready !== 1'b1 || mem_re !== 1'b0)
            begin bad++; $display("FAIL b2b_idle got=rdy%b re%b want=rdy1 re0", req_ready, mem_re); end
        $display("txn back-to-back word+byte wdata=cd223344");
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_lanes();
        test_half();
        test_rejects();
        test_reset_midop();
        test_write_suppress();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
